position_ring_ctrl: RTL

POSITION_RING_CTRL -- requirements
Module: position_ring_ctrl

---
 rtl/position_ring_ctrl_if.sv | 36 +++
 rtl/position_ring_ctrl.sv | 185 ++++++++++++++++++
 2 files changed

// File: rtl/position_ring_ctrl_if.sv
// position_ring_ctrl_if
//   Bundles the control/status signals between the position ring controller
//   and its environment: the timestep request side, per-node status flags,
//   the downstream handshake and the controller's registered outputs.
//   Ports (all signals, grouped by modport):
//     master : drives start, abort, done_batch, done_all, in_flight, ds_ready;
//              observes dispatch, double_buffer, busy, step_done,
//              batch_count, error
//     slave  : the controller side (mirror of master)
interface position_ring_ctrl_if #(
  parameter int NNODES  = 8,
  parameter int BATCH_W = 16
);
  logic               start;
  logic               abort;
  logic [NNODES-1:0]  done_batch;
  logic [NNODES-1:0]  done_all;
  logic [NNODES-1:0]  in_flight;
  logic               ds_ready;
  logic [1:0]         dispatch;
  logic               double_buffer;
  logic               busy;
  logic               step_done;
  logic [BATCH_W-1:0] batch_count;
  logic               error;

  modport master (
    output start, abort, done_batch, done_all, in_flight, ds_ready,
    input  dispatch, double_buffer, busy, step_done, batch_count, error
  );

  modport slave (
    input  start, abort, done_batch, done_all, in_flight, ds_ready,
    output dispatch, double_buffer, busy, step_done, batch_count, error
  );
endinterface

// File: rtl/position_ring_ctrl.sv
// position_ring_ctrl
//   Sequences one timestep of the position ring: restart the nodes, then
//   repeatedly load a batch, let it settle, run until every node reports the
//   batch complete with nothing left in flight, and drain into the force
//   pipeline until all nodes have exhausted their cells.
//   Ports:
//     clk   : single clock, rising edge
//     reset : synchronous, active-high
//     bus   : position_ring_ctrl_if.slave (start/abort, node flags,
//             ds_ready in; dispatch, double_buffer, busy, step_done,
//             batch_count, error out -- all outputs registered)
//   Build option:
//     POS_RING_WATCHDOG_EN : when defined, a RUN-state watchdog of TIMEOUT
//                            cycles sets the sticky error flag and restarts
//                            the ring; when undefined error is tied to 0.
//
//   state  | meaning
//   -------+------------------------------------------------------------
//   IDLE   | waiting for start, ring idle (dispatch 00)
//   INIT   | one-cycle ring restart (dispatch 11), batch count cleared
//   LOAD   | one-cycle batch load (dispatch 01), batch count incremented
//   SETTLE | one cycle of run while node done flags clear (dispatch 10)
//   RUN    | running batch until all done_batch and no in_flight
//   DRAIN  | holding run until the force pipeline takes the neighbor set
//   FINISH | one-cycle step_done, bank select flips on exit
module position_ring_ctrl #(
  parameter int NNODES  = 8,
  parameter int BATCH_W = 16,
  parameter int TIMEOUT = 4096
) (
  input  logic                 clk,
  input  logic                 reset,
  position_ring_ctrl_if.slave  bus
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_INIT,
    S_LOAD,
    S_SETTLE,
    S_RUN,
    S_DRAIN,
    S_FINISH
  } state_t;

  localparam logic [1:0] DISP_RUN_CLR = 2'b00;
  localparam logic [1:0] DISP_LOAD    = 2'b01;
  localparam logic [1:0] DISP_RUN     = 2'b10;
  localparam logic [1:0] DISP_RESTART = 2'b11;

  logic [NNODES-1:0] done_batch;
  logic [NNODES-1:0] done_all;
  logic [NNODES-1:0] in_flight;

  assign done_batch = bus.done_batch;
  assign done_all   = bus.done_all;
  assign in_flight  = bus.in_flight;

  state_t             state_q, state_d;
  logic [1:0]         dispatch_q, dispatch_d;
  logic               double_buffer_q, double_buffer_d;
  logic               busy_q, busy_d;
  logic               step_done_q, step_done_d;
  logic [BATCH_W-1:0] batch_count_q, batch_count_d;

  logic batch_end;
  logic abort_hit;
  logic restart_pulse;
  logic wd_expire;

  assign batch_end = (&done_batch) && !(|in_flight);
  assign abort_hit = bus.abort && (state_q != S_IDLE);

`ifdef POS_RING_WATCHDOG_EN
  localparam int WD_W = $clog2(TIMEOUT + 1);

  logic [WD_W-1:0] wd_q, wd_d;
  logic            error_q, error_d;

  // Counter sits at zero outside RUN, so it is already clear on RUN entry.
  // Expiry on the TIMEOUT-th RUN cycle; a batch end in that cycle wins.
  assign wd_expire = (state_q == S_RUN) && !batch_end &&
                     (wd_q == WD_W'(TIMEOUT - 1));

  always_comb begin
    wd_d    = (state_q == S_RUN) ? wd_q + 1'b1 : '0;
    error_d = error_q | (wd_expire && !abort_hit);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      wd_q    <= '0;
      error_q <= 1'b0;
    end else begin
      wd_q    <= wd_d;
      error_q <= error_d;
    end
  end

  assign bus.error = error_q;
`else
  // TIMEOUT only matters when the watchdog is built in.
  localparam int unused_timeout = TIMEOUT;

  assign wd_expire = 1'b0;
  assign bus.error = 1'b0;
`endif

  always_comb begin
    state_d         = state_q;
    double_buffer_d = double_buffer_q;
    batch_count_d   = batch_count_q;
    restart_pulse   = 1'b0;

    case (state_q)
      S_IDLE:   if (bus.start) state_d = S_INIT;
      S_INIT:   state_d = S_LOAD;
      S_LOAD:   state_d = S_SETTLE;
      S_SETTLE: state_d = S_RUN;
      S_RUN: begin
        if (batch_end) begin
          state_d = (&done_all) ? S_FINISH : S_DRAIN;
        end else if (wd_expire) begin
          state_d       = S_IDLE;
          restart_pulse = 1'b1;
        end
      end
      S_DRAIN:  if (bus.ds_ready) state_d = S_LOAD;
      S_FINISH: begin
        state_d         = S_IDLE;
        double_buffer_d = ~double_buffer_q;
      end
      default:  state_d = S_IDLE;
    endcase

    // Abort overrides whatever the state wanted, including a finishing
    // timestep's bank flip.
    if (abort_hit) begin
      state_d         = S_IDLE;
      restart_pulse   = 1'b1;
      double_buffer_d = double_buffer_q;
    end

    if (state_d == S_INIT) batch_count_d = '0;
    if (state_d == S_LOAD) batch_count_d = batch_count_q + 1'b1;

    // Outputs are decoded from the next state so they appear registered in
    // the same cycle the new state does.
    case (state_d)
      S_INIT:                    dispatch_d = DISP_RESTART;
      S_LOAD:                    dispatch_d = DISP_LOAD;
      S_SETTLE, S_RUN, S_DRAIN:  dispatch_d = DISP_RUN;
      default:                   dispatch_d = DISP_RUN_CLR;
    endcase
    if (restart_pulse) dispatch_d = DISP_RESTART;

    busy_d      = (state_d != S_IDLE);
    step_done_d = (state_d == S_FINISH);
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q         <= S_IDLE;
      dispatch_q      <= DISP_RESTART;
      double_buffer_q <= 1'b0;
      busy_q          <= 1'b0;
      step_done_q     <= 1'b0;
      batch_count_q   <= '0;
    end else begin
      state_q         <= state_d;
      dispatch_q      <= dispatch_d;
      double_buffer_q <= double_buffer_d;
      busy_q          <= busy_d;
      step_done_q     <= step_done_d;
      batch_count_q   <= batch_count_d;
    end
  end

  assign bus.dispatch      = dispatch_q;
  assign bus.double_buffer = double_buffer_q;
  assign bus.busy          = busy_q;
  assign bus.step_done     = step_done_q;
  assign bus.batch_count   = batch_count_q;

endmodule
